cdb_scheduler: RTL
==================

# cdb_scheduler

- Producer end of the common data bus (CDB) that issue queues snoop for wakeup.
- Each execution-unit issue port requests a writeback slot a fixed number of cycles ahead; the block grants at most one owner per future cycle and keeps a reservation shift register.
- In the granted cycle it broadcasts the destination physical tag on `cdb`.
- It publishes slot occupancy on `cdb_slots` so issue queues issue only when their result slot is free.

## Interface

Parameters:
- `NUM_EU`, 4: number of execution-unit request ports.
- `PRF_SIZE`, 128: physical register count; `PRF_ADDR` = $clog2(PRF_SIZE).
- `MAX_LAT`, 4: longest supported EU latency and reservation horizon (≥2); `LAT_W` = $clog2(MAX_LAT+1).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  NUM_EU  per-EU slot request, same cycle the EU issues.
- `req_lat`  in  NUM_EU*LAT_W  per-EU latency L; port i occupies bits [i*LAT_W +: LAT_W].
- `req_tag`  in  NUM_EU*PRF_ADDR  per-EU destination tag pD.
- `gnt`  out  NUM_EU  combinational grant; the EU issues only if its gnt bit is 1.
- `cdb_slots`  out  MAX_LAT  bit k-1 = 1 means a latency-k request is refused this cycle.
- `cdb`  out  PRF_ADDR  broadcast tag.
- `cdb_v`  out  1  broadcast valid.

## Operation

State:
- Registers `slot_v[0..MAX_LAT-1]` and `slot_tag[0..MAX_LAT-1]`. During cycle t, slot[k] holds the broadcast for cycle t+k.
- `cdb` = slot_tag[0], `cdb_v` = slot_v[0], both driven directly from flops.
- A virtual slot[MAX_LAT] is always empty.

Occupancy:
- `cdb_slots[k-1]` = slot_v[k] for k = 1..MAX_LAT, taken from registered state only.
- `cdb_slots[MAX_LAT-1]` is therefore always 0.

Eligibility and arbitration:
- Request i is eligible when `req[i]`, 1 ≤ L ≤ MAX_LAT, and slot_v[L] = 0.
- L = 0 or L > MAX_LAT is never granted and does not disturb other ports.
- Among eligible requests with equal L, exactly one is granted; the arbitration policy is set under Configuration.
- Requests with different L never conflict with each other.

Every clock edge:
- slot[k] <= slot[k+1] for k = 0..MAX_LAT-2.
- slot[MAX_LAT-1] <= empty.
- Then each granted request writes {1, tag} into slot[L-1]. The grant write overrides the shift into that index, which is always empty by construction.

Reset:
- While `reset` = 0 at an edge, all slot_v, `cdb_v`, `cdb` and the round-robin pointer clear to 0.
- `gnt` is forced to 0 while reset is low.
- In-flight reservations are discarded, and EU pipelines are reset together with this block.

## Timing

- Request at cycle t with latency L and `gnt` = 1 means tag on `cdb` with `cdb_v` = 1 in exactly cycle t+L.
- `gnt` is combinational from `req`/`req_lat` and registered slot state, with no added cycle.
- `cdb_slots` reflects the edge at the start of the current cycle. Issue queues combine it with their own candidate's L.
- A slot freed by the shift becomes grantable in the same cycle it becomes visible: occupancy moves from bit k to bit k-1 each cycle.
- `cdb_v` drops to 0 in any cycle with no reservation; `cdb` holds its last value, not 0.
- Throughput: at most one broadcast per cycle; up to MAX_LAT grants per cycle when latencies differ.

## Configuration

- `CDB_RR_EN` defined: a round-robin pointer (width $clog2(NUM_EU)) selects the winner among same-L contenders, searching from the pointer upward with wrap. After any cycle with at least one granted conflict, the pointer advances to (last conflict winner + 1) mod NUM_EU.
- `CDB_RR_EN` undefined: fixed priority, lowest port index wins. No pointer register exists.

## Structure

- Shared package `cdb_pkg` holds:
  - `PRF_ADDR` derivation;
  - the `cdb_slot_t` typedef {valid, tag};
  - the `LAT_W` function;
  - latency localparams shared with iqueue and the EUs.
- One sub-module, `cdb_arbiter`: a NUM_EU-wide one-hot arbiter, fixed or round-robin per macro, instantiated once per latency value 1..MAX_LAT.

## Test plan

- Reset with reset = 0 for 2 cycles → cdb_v = 0, cdb_slots = 0, gnt = 0. Release, then req[0] = 1, L = 3, tag 0x2A at t = 5 → gnt[0] = 1 at t5; cdb = 0x2A, cdb_v = 1 at t8 only.
- Same-slot conflict: ports 1 and 2 both at t10 with L = 2, tags 0x11/0x22.
  - Fixed priority: gnt = 0b0010, 0x11 at t12.
  - `CDB_RR_EN`: repeat at t20 → port 2 wins.
- Occupied slot: grant L = 4 at t30 → cdb_slots = 0b0100 at t31, 0b0010 at t32. A port requesting L = 2 at t32 is refused; L = 1 at t32 is granted.
- Mixed latencies: four ports, L = 1, 2, 3, 4 at t40 → all gnt; tags broadcast back-to-back t41..t44 with cdb_v continuously 1.
- Illegal latency: L = 0 and L = 5 requests → gnt = 0, no slot changes. A legal L = 1 request on another port in the same cycle is still granted.
- Reset mid-flight: reservations for t52 and t53, reset low at t51 edge → cdb_v = 0 at t52 and t53, cdb_slots = 0.

Source files
------------

// File: rtl/cdb_pkg.sv
// +----------------------------------------------------------------------------+
// | cdb_pkg : shared CDB widths, slot record and latency constants             |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package cdb_pkg;

  localparam int CDB_NUM_EU   = 4;
  localparam int CDB_PRF_SIZE = 128;
  localparam int CDB_MAX_LAT  = 4;

  function automatic int prf_addr_w(input int prf_size);
    return $clog2(prf_size);
  endfunction

  function automatic int lat_w(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction

  function automatic int ptr_w(input int num_eu);
    return (num_eu > 1) ? $clog2(num_eu) : 1;
  endfunction

  localparam int CDB_PRF_ADDR = prf_addr_w(CDB_PRF_SIZE);

  typedef struct packed {
    logic                    valid;
    logic [CDB_PRF_ADDR-1:0] tag;
  } cdb_slot_t;

endpackage

`default_nettype wire

// File: rtl/cdb_if.sv
// +----------------------------------------------------------------------------+
// | cdb_if : EU writeback-slot request / CDB broadcast bundle                  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface cdb_if
  import cdb_pkg::*;
#(
  parameter int NUM_EU   = CDB_NUM_EU,
  parameter int PRF_SIZE = CDB_PRF_SIZE,
  parameter int MAX_LAT  = CDB_MAX_LAT
);
  localparam int PRF_ADDR = prf_addr_w(PRF_SIZE);
  localparam int LAT_W    = lat_w(MAX_LAT);

  logic [NUM_EU-1:0]          req;
  logic [NUM_EU*LAT_W-1:0]    req_lat;
  logic [NUM_EU*PRF_ADDR-1:0] req_tag;
  logic [NUM_EU-1:0]          gnt;
  logic [MAX_LAT-1:0]         cdb_slots;
  logic [PRF_ADDR-1:0]        cdb;
  logic                       cdb_v;

  modport master (output req, req_lat, req_tag, input gnt, cdb_slots, cdb, cdb_v);
  modport slave  (input req, req_lat, req_tag, output gnt, cdb_slots, cdb, cdb_v);

endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// +----------------------------------------------------------------------------+
// | cdb_arbiter : one-hot arbiter, fixed priority or round-robin (CDB_RR_EN)   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_EU = CDB_NUM_EU
) (
`ifdef CDB_RR_EN
  input  logic [ptr_w(NUM_EU)-1:0] ptr,
`endif
  input  logic [NUM_EU-1:0]        req,
  output logic [NUM_EU-1:0]        gnt
);

`ifdef CDB_RR_EN
  int   w_idx;
  logic w_found;

  // Search from the pointer upward, wrapping past the top port.
  always_comb begin
    gnt     = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int off = 0; off < NUM_EU; off++) begin
      w_idx = (int'(ptr) + off) % NUM_EU;
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
`else
  // Isolate the lowest set request bit.
  assign gnt = req & (~req + NUM_EU'(1));
`endif

endmodule

`default_nettype wire

// File: rtl/cdb_scheduler.sv
// +----------------------------------------------------------------------------+
// | cdb_scheduler : CDB writeback-slot reservation and tag broadcast           |
// | Config macro CDB_RR_EN: round-robin among same-latency contenders.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module cdb_scheduler
  import cdb_pkg::*;
#(
  parameter int NUM_EU   = CDB_NUM_EU,
  parameter int PRF_SIZE = CDB_PRF_SIZE,
  parameter int MAX_LAT  = CDB_MAX_LAT
) (
  input  logic clk,
  input  logic reset,
  cdb_if.slave bus
);
  localparam int PRF_ADDR = prf_addr_w(PRF_SIZE);
  localparam int LAT_W    = lat_w(MAX_LAT);

  logic [MAX_LAT-1:0]             r_slot_v;
  logic [PRF_ADDR-1:0]            r_slot_tag [MAX_LAT];
  logic [MAX_LAT:0]               w_occ;
  logic [MAX_LAT-1:0][NUM_EU-1:0] w_lreq;
  logic [MAX_LAT-1:0][NUM_EU-1:0] w_lgnt;
  logic [PRF_ADDR-1:0]            w_ltag [MAX_LAT];
  logic [MAX_LAT-1:0]             w_lhit;
  logic [NUM_EU-1:0]              w_gnt;

  // Top bit models the virtual slot beyond the horizon, which is always free.
  assign w_occ = {1'b0, r_slot_v};

  // Row j collects eligible requests of latency j+1.
  always_comb begin
    w_lreq = '0;
    for (int j = 0; j < MAX_LAT; j++) begin
      for (int i = 0; i < NUM_EU; i++) begin
        w_lreq[j][i] = bus.req[i] && !w_occ[j+1] &&
                       (bus.req_lat[i*LAT_W +: LAT_W] == LAT_W'(j + 1));
      end
    end
  end

`ifdef CDB_RR_EN
  localparam int PTR_W = ptr_w(NUM_EU);
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_next;
`endif

  for (genvar j = 0; j < MAX_LAT; j++) begin : g_lat_arb
    cdb_arbiter #(.NUM_EU(NUM_EU)) u_arb (
`ifdef CDB_RR_EN
      .ptr (r_ptr),
`endif
      .req (w_lreq[j]),
      .gnt (w_lgnt[j])
    );
  end

  always_comb begin
    w_gnt = '0;
    for (int j = 0; j < MAX_LAT; j++) begin
      w_ltag[j] = '0;
      w_lhit[j] = |w_lgnt[j];
      w_gnt     = w_gnt | w_lgnt[j];
      for (int i = 0; i < NUM_EU; i++) begin
        if (w_lgnt[j][i]) w_ltag[j] = bus.req_tag[i*PRF_ADDR +: PRF_ADDR];
      end
    end
  end

`ifdef CDB_RR_EN
  // The highest latency with a real conflict decides where the search restarts.
  always_comb begin
    w_ptr_next = r_ptr;
    for (int j = 0; j < MAX_LAT; j++) begin
      if ($countones(w_lreq[j]) > 1) begin
        for (int i = 0; i < NUM_EU; i++) begin
          if (w_lgnt[j][i]) w_ptr_next = PTR_W'((i + 1) % NUM_EU);
        end
      end
    end
  end
`endif

  assign bus.gnt       = reset ? w_gnt : '0;
  assign bus.cdb_slots = {1'b0, r_slot_v[MAX_LAT-1:1]};
  assign bus.cdb       = r_slot_tag[0];
  assign bus.cdb_v     = r_slot_v[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_slot_v <= '0;
      for (int k = 0; k < MAX_LAT; k++) r_slot_tag[k] <= '0;
`ifdef CDB_RR_EN
      r_ptr <= '0;
`endif
    end else begin
      // Tags only move with a valid entry so cdb holds its last broadcast.
      for (int k = 0; k < MAX_LAT - 1; k++) begin
        r_slot_v[k] <= r_slot_v[k+1];
        if (r_slot_v[k+1]) r_slot_tag[k] <= r_slot_tag[k+1];
      end
      r_slot_v[MAX_LAT-1] <= 1'b0;
      for (int k = 0; k < MAX_LAT; k++) begin
        if (w_lhit[k]) begin
          r_slot_v[k]   <= 1'b1;
          r_slot_tag[k] <= w_ltag[k];
        end
      end
`ifdef CDB_RR_EN
      r_ptr <= w_ptr_next;
`endif
    end
  end

endmodule

`default_nettype wire
